param_lfsr: RTL and testbench

PARAM_LFSR -- requirements
Module: param_lfsr

---
 rtl/param_lfsr.sv | 117 +++++++++++
 tb/tb_param_lfsr.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/param_lfsr.sv
// -----------------------------------------------------------------------------
// param_lfsr
//   Parameterised linear feedback shift register. It can be built in Fibonacci
//   or Galois form. It also measures the length of the cycle it is running.
//   An internal start register holds the state set at the last reset or load.
//   Each time a step returns the state to that start value, the block emits a
//   one-cycle wrap pulse and publishes the number of steps taken as the period.
//
// Parameters
//   WIDTH  : state width (3..32)
//   TAPS   : WIDTH-bit feedback tap mask
//   SEED   : non-zero reset state; also used in place of a rejected zero load
//   GALOIS : 0 = Fibonacci form, 1 = Galois form
//
// Ports
//   clk      in   single clock; all state changes on its rising edge
//   rst      in   synchronous active-high reset
//   en       in   advance the state one step
//   load     in   load load_val (has priority over en)
//   load_val in   value to load; zero is rejected and SEED is used instead
//   rnd      out  current LFSR state (registered)
//   wrap     out  one-cycle pulse when the state returns to the start value
//   period   out  step count of the last completed cycle
//   load_err out  one-cycle pulse when an all-zero load is rejected
// -----------------------------------------------------------------------------
module param_lfsr #(
  parameter int unsigned           WIDTH  = 5,
  parameter logic [WIDTH-1:0]      TAPS   = 5'b10100,
  parameter logic [WIDTH-1:0]      SEED   = 5'b11100,
  parameter bit                    GALOIS = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] rnd,
  output logic             wrap,
  output logic [WIDTH-1:0] period,
  output logic             load_err
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_start;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_period;
  logic             r_wrap;
  logic             r_load_err;

  logic [WIDTH-1:0] w_fib;
  logic [WIDTH-1:0] w_gal;
  logic [WIDTH-1:0] w_next;
  logic [WIDTH-1:0] w_cnt_inc;
  logic             w_load_zero;

  // Fibonacci form: shift left and feed the parity of the tapped bits into bit 0.
  assign w_fib = {r_q[WIDTH-2:0], ^(r_q & TAPS)};

  // Galois form: the MSB rotates into bit 0. On the way up it is also XORed
  // into every tapped position.
  always_comb begin
    w_gal    = '0;
    w_gal[0] = r_q[WIDTH-1];
    for (int i = 1; i < WIDTH; i++) begin
      w_gal[i] = r_q[i-1] ^ (TAPS[i-1] & r_q[WIDTH-1]);
    end
  end

  assign w_next      = GALOIS ? w_gal : w_fib;
  assign w_cnt_inc   = r_cnt + ONE;   // wraps modulo 2^WIDTH by design
  assign w_load_zero = (load_val == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q        <= SEED;
      r_start    <= SEED;
      r_cnt      <= '0;
      r_period   <= '0;
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      // Both flags are pulses. They drop unless this edge sets them again.
      r_wrap     <= 1'b0;
      r_load_err <= 1'b0;
      if (load) begin
        // A load restarts the measurement. No step is counted, even if en is high.
        r_cnt <= '0;
        if (w_load_zero) begin
          r_q        <= SEED;
          r_start    <= SEED;
          r_load_err <= 1'b1;
        end else begin
          r_q     <= load_val;
          r_start <= load_val;
        end
      end else if (en) begin
        r_q <= w_next;
        // The step that lands back on the start state closes the cycle. It counts as a step.
        if (w_next == r_start) begin
          r_wrap   <= 1'b1;
          r_period <= w_cnt_inc;
          r_cnt    <= '0;
        end else begin
          r_cnt <= w_cnt_inc;
        end
      end
    end
  end

  assign rnd      = r_q;
  assign wrap     = r_wrap;
  assign period   = r_period;
  assign load_err = r_load_err;

endmodule

// File: tb/tb_param_lfsr.sv
// -----------------------------------------------------------------------------
// tb_param_lfsr
//   Bench for param_lfsr. It runs a Fibonacci instance (defaults) and a Galois
//   instance side by side on shared inputs. Each instance is compared every
//   cycle against a reference model. That model steps the polynomial with plain
//   integer arithmetic. It measures cycle length by counting steps back to the
//   recorded start value.
// -----------------------------------------------------------------------------
module tb_param_lfsr;

  localparam int W     = 5;
  localparam int MASK  = 31;
  localparam int TAPS  = 20;   // 5'b10100
  localparam int SEED  = 28;   // 5'b11100

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst      = 1'b1;
  logic         en       = 1'b0;
  logic         load     = 1'b0;
  logic [W-1:0] load_val = '0;

  logic [W-1:0] f_rnd, f_period, g_rnd, g_period;
  logic         f_wrap, f_err, g_wrap, g_err;

  param_lfsr #(.WIDTH(5), .TAPS(5'b10100), .SEED(5'b11100), .GALOIS(1'b0)) u_fib (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .rnd(f_rnd), .wrap(f_wrap), .period(f_period), .load_err(f_err)
  );

  param_lfsr #(.WIDTH(5), .TAPS(5'b10100), .SEED(5'b11100), .GALOIS(1'b1)) u_gal (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .rnd(g_rnd), .wrap(g_wrap), .period(g_period), .load_err(g_err)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Index 0 = Fibonacci instance, index 1 = Galois instance.
  int m_q[2], m_start[2], m_cnt[2], m_period[2];
  bit m_wrap[2];
  bit m_err;

  function automatic int ref_step(input int q, input bit galois);
    int nq;
    nq = (q << 1) & MASK;
    if (!galois) begin
      nq = nq | ($countones(q & TAPS) % 2);
    end else if (q >= 16) begin
      nq = nq ^ (((TAPS << 1) & MASK) | 1);
    end
    return nq;
  endfunction

  task automatic model_edge(input bit r, input bit e, input bit l, input int v);
    int nq;
    m_err = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_wrap[k] = 1'b0;
      if (r) begin
        m_q[k] = SEED; m_start[k] = SEED; m_cnt[k] = 0; m_period[k] = 0;
      end else if (l) begin
        m_q[k]     = (v == 0) ? SEED : v;
        m_start[k] = m_q[k];
        m_cnt[k]   = 0;
        if (v == 0) m_err = 1'b1;
      end else if (e) begin
        nq = ref_step(m_q[k], k == 1);
        m_cnt[k] = m_cnt[k] + 1;
        if (nq == m_start[k]) begin
          m_wrap[k]   = 1'b1;
          m_period[k] = m_cnt[k] % (MASK + 1);
          m_cnt[k]    = 0;
        end
        m_q[k] = nq;
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input bit r, input bit e, input bit l, input int v);
    rst = r; en = e; load = l; load_val = v[W-1:0];
    @(posedge clk);
    model_edge(r, e, l, v);
    exp_q.push_back(m_q[0][W-1:0]);
    #1;
    check("fib_rnd",    f_rnd,    exp_q.pop_front());
    check("fib_wrap",   f_wrap,   m_wrap[0]);
    check("fib_period", f_period, m_period[0]);
    check("fib_err",    f_err,    m_err);
    check("gal_rnd",    g_rnd,    m_q[1]);
    check("gal_wrap",   g_wrap,   m_wrap[1]);
    check("gal_period", g_period, m_period[1]);
    check("gal_err",    g_err,    m_err);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    cycle(1'b1, 1'b0, 1'b0, 0);
    cycle(1'b1, 1'b1, 1'b1, 7);
    check("reset_rnd", f_rnd, 5'b11100);
    check("reset_period", f_period, 0);

    // Two steps from the seed
    steps(1);
    check("step1_rnd", f_rnd, 5'b11000);
    steps(1);
    check("step2_rnd", f_rnd, 5'b10001);

    // Full maximal cycle, then a second one
    steps(28);
    check("pre_wrap", f_wrap, 1'b0);
    steps(1);
    check("wrap31_pulse", f_wrap, 1'b1);
    check("wrap31_period", f_period, 31);
    check("wrap31_rnd", f_rnd, 5'b11100);
    steps(1);
    check("wrap31_drop", f_wrap, 1'b0);
    steps(30);
    check("wrap62_pulse", f_wrap, 1'b1);
    check("wrap62_period", f_period, 31);

    // Zero load is rejected and falls back to SEED
    steps(4);
    cycle(1'b0, 1'b1, 1'b1, 0);
    check("zload_rnd", f_rnd, 5'b11100);
    check("zload_err", f_err, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 0);
    check("zload_err_drop", f_err, 1'b0);

    // Load together with en: the load wins, and no step is counted
    cycle(1'b0, 1'b1, 1'b1, 1);
    check("load_rnd", f_rnd, 5'b00001);
    steps(31);
    check("load_wrap", f_wrap, 1'b1);
    check("load_period", f_period, 31);
    check("load_wrap_rnd", f_rnd, 5'b00001);

    // Hold for 3 cycles mid-sequence
    steps(10);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 0);
    steps(21);
    check("hold_wrap", f_wrap, 1'b1);
    check("hold_period", f_period, 31);

    // Reset at step 10 discards the partial count
    steps(10);
    cycle(1'b1, 1'b1, 1'b0, 0);
    check("midrst_rnd", f_rnd, 5'b11100);
    check("midrst_period", f_period, 0);
    steps(30);
    check("midrst_nowrap", f_wrap, 1'b0);
    steps(1);
    check("midrst_wrap", f_wrap, 1'b1);
    check("midrst_wrap_period", f_period, 31);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      bit r, e, l;
      int v;
      r = ($urandom_range(0, 99) < 2);
      l = ($urandom_range(0, 99) < 5);
      e = ($urandom_range(0, 99) < 75);
      v = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, MASK);
      cycle(r, e, l, v);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
